// File: rtl/controller_link_tx.sv
// Controller-side serial transmitter: snapshots one controller sample and shifts it out
// MSB first as a 24-bit frame on a generated clock, then holds an idle gap for resync.
module controller_link_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned GAP_CYCLES = 2000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  buttons_in,
  input  logic [7:0]  joystick_x_in,
  input  logic [7:0]  joystick_y_in,
  input  logic        frame_valid_in,
  output logic        frame_ready_out,
  output logic        chip_data_out,
  output logic        chip_clk_out,
  output logic        busy_out,
  output logic [15:0] frames_sent_out
);

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned HALF_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_GAP,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t               state;
  logic [GAP_W-1:0]     gap_cnt;
  logic [HALF_W-1:0]    half_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   shreg;

  // Reset is asynchronous so the link lines drop immediately, even mid-frame.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_GAP;
      gap_cnt         <= '0;
      half_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      frame_ready_out <= 1'b0;
      chip_data_out   <= 1'b0;
      chip_clk_out    <= 1'b0;
      busy_out        <= 1'b0;
      frames_sent_out <= '0;
    end else begin
      case (state)
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt         <= '0;
            frame_ready_out <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        ST_IDLE: begin
          if (frame_valid_in) begin
            shreg           <= {buttons_in, joystick_x_in, joystick_y_in};
            frame_ready_out <= 1'b0;
            busy_out        <= 1'b1;
            state           <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          chip_data_out <= shreg[FRAME_W-1];
          chip_clk_out  <= 1'b0;
          half_cnt      <= '0;
          bit_cnt       <= '0;
          state         <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (half_cnt == HALF_W'(CLK_DIV - 1)) begin
            half_cnt <= '0;
            if (!chip_clk_out) begin
              chip_clk_out <= 1'b1;
            end else begin
              // Falling edge: data only moves while the clock line is low.
              chip_clk_out <= 1'b0;
              if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                chip_data_out   <= 1'b0;
                frames_sent_out <= frames_sent_out + 16'd1;
                busy_out        <= 1'b0;
                gap_cnt         <= '0;
                state           <= ST_GAP;
              end else begin
                bit_cnt       <= bit_cnt + BIT_W'(1);
                shreg         <= {shreg[FRAME_W-2:0], 1'b0};
                chip_data_out <= shreg[FRAME_W-2];
              end
            end
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end
        end

        default: state <= ST_GAP;
      endcase
    end
  end

endmodule
